tx_frame_sequencer: RTL and testbench

- Frame-level controller for the 802.11a transmit bit path.
- Sequences one PPDU as a serial bit stream in this order: PLCP preamble, SIGNAL field, SERVICE field, PSDU, TAIL bits, PAD bits.
- Drives the scrambler control lines: seed load, advance, and output-mux select.
- Sits between the MAC-side byte/bit source and the existing Scrambler/output mux, and replaces the ad-hoc FSM in the transmitter top.

---
 rtl/tx_frame_sequencer_pkg.sv | 28 ++
 rtl/tx_frame_sequencer_if.sv | 38 +++
 rtl/tx_frame_sequencer_signal_builder.sv | 10 +
 rtl/tx_frame_sequencer.sv | 104 ++++++++++
 tb/tb_tx_frame_sequencer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/tx_frame_sequencer_pkg.sv
// tx_frame_pkg: shared state encoding, 802.11a RATE codes, field sizes and N_DBPS lookup
package tx_frame_pkg;
  typedef enum logic [2:0] {IDLE, PREAMBLE, SIGNAL, SERVICE, PSDU, TAIL, PAD} state_t;
  localparam logic [3:0] RATE_6  = 4'b1101;
  localparam logic [3:0] RATE_9  = 4'b1111;
  localparam logic [3:0] RATE_12 = 4'b0101;
  localparam logic [3:0] RATE_18 = 4'b0111;
  localparam logic [3:0] RATE_24 = 4'b1001;
  localparam logic [3:0] RATE_36 = 4'b1011;
  localparam logic [3:0] RATE_48 = 4'b0001;
  localparam logic [3:0] RATE_54 = 4'b0011;
  localparam int SIGNAL_BITS  = 24;
  localparam int SERVICE_BITS = 16;
  localparam int TAIL_BITS    = 6;
  function automatic logic [7:0] ndbps(input logic [3:0] rate);
    case (rate)
      RATE_6:  return 8'd24;
      RATE_9:  return 8'd36;
      RATE_12: return 8'd48;
      RATE_18: return 8'd72;
      RATE_24: return 8'd96;
      RATE_36: return 8'd144;
      RATE_48: return 8'd192;
      RATE_54: return 8'd216;
      default: return 8'd24;
    endcase
  endfunction
endpackage

// File: rtl/tx_frame_sequencer_if.sv
// tx_frame_sequencer_if: frame request, PSDU bit source, output bit handshake and scrambler control
// master = MAC/test side (drives start, rate, length, data_in, out_ready)
// slave  = sequencer side (drives data_req, tx_bit, tx_valid, scr_*, busy, done, error)
// Optional: TX_BITCOUNT_EN adds tx_bit_count.
interface tx_frame_sequencer_if;
  logic        start;
  logic [3:0]  rate;
  logic [11:0] length;
  logic        data_in;
  logic        out_ready;
  logic        data_req;
  logic        tx_bit;
  logic        tx_valid;
  logic        scr_init;
  logic [6:0]  scr_seed;
  logic        scr_advance;
  logic        scr_select;
  logic        busy;
  logic        done;
  logic        error;
`ifdef TX_BITCOUNT_EN
  logic [15:0] tx_bit_count;
`endif
  modport master (
    output start, rate, length, data_in, out_ready,
    input  data_req, tx_bit, tx_valid, scr_init, scr_seed, scr_advance, scr_select, busy, done, error
`ifdef TX_BITCOUNT_EN
    , tx_bit_count
`endif
  );
  modport slave (
    input  start, rate, length, data_in, out_ready,
    output data_req, tx_bit, tx_valid, scr_init, scr_seed, scr_advance, scr_select, busy, done, error
`ifdef TX_BITCOUNT_EN
    , tx_bit_count
`endif
  );
endinterface

// File: rtl/tx_frame_sequencer_signal_builder.sv
// tx_signal_builder: combinational 24-bit SIGNAL field, bit 0 transmitted first
// Ports: i_rate (RATE code, R1 = i_rate[3]), i_length (PSDU bytes), o_signal (word, parity included)
module tx_signal_builder (
  input  logic [3:0]  i_rate,
  input  logic [11:0] i_length,
  output logic [23:0] o_signal
);
  assign o_signal = {6'b000000, ^{i_rate, i_length}, i_length, 1'b0,
                     i_rate[0], i_rate[1], i_rate[2], i_rate[3]};
endmodule

// File: rtl/tx_frame_sequencer.sv
// tx_frame_sequencer: 802.11a PPDU bit sequencer (preamble, SIGNAL, SERVICE, PSDU, TAIL, PAD) with scrambler control
// Ports: i_clk, i_rst (async, active-high), bus (tx_frame_sequencer_if.slave)
// Optional: TX_BITCOUNT_EN adds bus.tx_bit_count, transfers since the last accepted start.
module tx_frame_sequencer
  import tx_frame_pkg::*;
#(
  parameter int                       PREAMBLE_BITS    = 96,
  parameter logic [PREAMBLE_BITS-1:0] PREAMBLE_PATTERN = 96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA,
  parameter logic [6:0]               SCR_SEED         = 7'h5D
) (
  input logic i_clk,
  input logic i_rst,
  tx_frame_sequencer_if.slave bus
);
  localparam int PW = $clog2(PREAMBLE_BITS);
  state_t      r_state;
  logic [14:0] r_cnt;
  logic [7:0]  r_sc;
  logic [3:0]  r_rate;
  logic [11:0] r_len;
  logic [6:0]  r_seed;
  logic        r_busy, r_done, r_error, r_scr_init;
  logic [23:0] w_sig;
  logic [7:0]  w_ndbps, w_sc_next;
  logic        w_xfer, w_last, w_phase, w_accept;
  state_t      w_next;
  tx_signal_builder u_sig (.i_rate(r_rate), .i_length(r_len), .o_signal(w_sig));
  always_comb begin
    w_ndbps   = ndbps(r_rate);
    w_sc_next = (r_sc == w_ndbps - 8'd1) ? 8'd0 : r_sc + 8'd1;
    w_phase   = r_state inside {SERVICE, PSDU, TAIL, PAD};
    w_xfer    = (r_state != IDLE) && bus.out_ready;
    w_accept  = bus.start && bus.rate[0] && (bus.length != 12'd0);
    w_last    = r_state == PREAMBLE ? r_cnt == 15'(PREAMBLE_BITS - 1) :
                r_state == SIGNAL   ? r_cnt == 15'(SIGNAL_BITS - 1) :
                r_state == SERVICE  ? r_cnt == 15'(SERVICE_BITS - 1) :
                r_state == PSDU     ? r_cnt == {r_len, 3'b000} - 15'd1 :
                r_state == TAIL     ? r_cnt == 15'(TAIL_BITS - 1) :
                r_state == PAD && r_sc == w_ndbps - 8'd1;
    // TAIL ends the frame only when it closes a whole OFDM symbol
    w_next    = r_state == PREAMBLE ? SIGNAL :
                r_state == SIGNAL   ? SERVICE :
                r_state == SERVICE  ? PSDU :
                r_state == PSDU     ? TAIL :
                r_state == TAIL && w_sc_next != 8'd0 ? PAD : IDLE;
  end
  assign bus.tx_valid    = r_state != IDLE;
  assign bus.tx_bit      = r_state == PREAMBLE ? PREAMBLE_PATTERN[PW'(PREAMBLE_BITS - 1) - r_cnt[PW-1:0]] :
                           r_state == SIGNAL   ? w_sig[r_cnt[4:0]] :
                           r_state == PSDU && bus.data_in;
  assign bus.data_req    = r_state == PSDU && bus.out_ready;
  assign bus.scr_advance = w_phase && bus.out_ready;
  assign bus.scr_select  = r_state inside {SERVICE, PSDU, PAD};
  assign bus.scr_init    = r_scr_init;
  assign bus.scr_seed    = r_seed;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.error       = r_error;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_sc       <= '0;
      r_rate     <= '0;
      r_len      <= '0;
      r_seed     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_scr_init <= 1'b0;
    end else begin
      r_seed     <= SCR_SEED;
      r_done     <= 1'b0;
      r_scr_init <= 1'b0;
      r_error    <= r_state == IDLE && bus.start && !w_accept;
      if (r_state == IDLE && w_accept) begin
        r_rate  <= bus.rate;
        r_len   <= bus.length;
        r_busy  <= 1'b1;
        r_cnt   <= '0;
        r_sc    <= '0;
        r_state <= PREAMBLE;
      end else if (w_xfer) begin
        r_cnt <= w_last ? '0 : r_cnt + 15'd1;
        if (w_phase) r_sc <= w_sc_next;
        if (w_last) begin
          r_state    <= w_next;
          r_busy     <= w_next != IDLE;
          r_done     <= w_next == IDLE;
          r_scr_init <= r_state == SIGNAL;
        end
      end
    end
  end
`ifdef TX_BITCOUNT_EN
  logic [15:0] r_bit_count;
  assign bus.tx_bit_count = r_bit_count;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_bit_count <= '0;
    else if (r_state == IDLE && w_accept) r_bit_count <= '0;
    else if (w_xfer) r_bit_count <= r_bit_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_tx_frame_sequencer.sv
// tb_tx_frame_sequencer: directed self-checking bench for tx_frame_sequencer
module tb_tx_frame_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  tx_frame_sequencer_if bus();
  tx_frame_sequencer dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  localparam logic [95:0] PRE = 96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
  int n_cmp = 0;
  int n_bad = 0;
  logic q[$];
  logic e[$];
  int first_v, done_cyc, n_dreq, n_init, init_at, viol, busy_bad, timed_out;

  function automatic int nd(input logic [3:0] r);
    case (r)
      4'b1101: return 24;
      4'b1111: return 36;
      4'b0101: return 48;
      4'b0111: return 72;
      4'b1001: return 96;
      4'b1011: return 144;
      4'b0001: return 192;
      4'b0011: return 216;
      default: return 0;
    endcase
  endfunction

  function automatic logic pat(input int i, input bit ones);
    return ones ? 1'b1 : logic'(i[0] ^ i[2] ^ i[5]);
  endfunction

  function automatic void build_exp(input logic [3:0] r, input logic [11:0] l, input bit ones);
    int n, body;
    e.delete();
    for (int i = 0; i < 96; i++) e.push_back(PRE[95-i]);
    for (int i = 3; i >= 0; i--) e.push_back(r[i]);
    e.push_back(1'b0);
    for (int i = 0; i < 12; i++) e.push_back(l[i]);
    e.push_back(^{r, l});
    for (int i = 0; i < 22; i++) e.push_back(1'b0);
    for (int i = 0; i < 8 * int'(l); i++) e.push_back(pat(i, ones));
    n = nd(r);
    body = ((22 + 8 * int'(l) + n - 1) / n) * n;
    for (int i = 16 + 8 * int'(l); i < body; i++) e.push_back(1'b0);
  endfunction

  function automatic int diff();
    int bad = 0;
    foreach (e[i]) if (i >= q.size() || q[i] !== e[i]) bad++;
    return bad;
  endfunction

  task automatic run_frame(input logic [3:0] r, input logic [11:0] l, input bit ones, input bit thr, input bit restart);
    int d = 0;
    q.delete();
    first_v = -1; done_cyc = -1; n_dreq = 0; n_init = 0; init_at = -1; viol = 0; busy_bad = 0; timed_out = 1;
    bus.start = 1'b1; bus.rate = r; bus.length = l; bus.out_ready = 1'b1; bus.data_in = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      bus.start = restart && c == 10;
      bus.out_ready = thr ? c[0] : 1'b1;
      bus.data_in = pat(d, ones);
      #1;
      if (bus.done) begin done_cyc = c; timed_out = 0; break; end
      if (bus.tx_valid && first_v < 0) first_v = c;
      if (bus.tx_valid && !bus.busy) busy_bad++;
      if (bus.scr_init) begin n_init++; init_at = q.size(); end
      if (!bus.out_ready && (bus.scr_advance || bus.data_req)) viol++;
      if (bus.data_req) begin n_dreq++; d++; end
      if (bus.tx_valid && bus.out_ready) q.push_back(bus.tx_bit);
    end
    bus.start = 1'b0;
    n_cmp++; if (timed_out != 0) begin n_bad++; $display("FAIL timeout: no done after 4000 cycles, got %0d bits", q.size()); end
  endtask

  task automatic test_reset;
    bus.start = 0; bus.rate = 0; bus.length = 0; bus.data_in = 0; bus.out_ready = 1;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++; if ({bus.tx_valid, bus.tx_bit, bus.data_req, bus.scr_init, bus.scr_seed, bus.scr_advance, bus.scr_select, bus.busy, bus.done, bus.error} !== 16'h0) begin
      n_bad++; $display("FAIL reset_outputs: got valid=%b busy=%b seed=%h, want all 0", bus.tx_valid, bus.busy, bus.scr_seed); end
    rst = 1'b0;
    @(posedge clk); #2;
    n_cmp++; if (bus.scr_seed !== 7'h5D || bus.tx_valid !== 1'b0) begin
      n_bad++; $display("FAIL idle_seed: got seed=%h valid=%b, want 5d 0", bus.scr_seed, bus.tx_valid); end
  endtask

  task automatic test_rate6_len1;
    logic [23:0] sig = 24'b110101_00000000000_0_000000;
    int sbad = 0;
    run_frame(4'b1101, 12'd1, 1'b1, 1'b0, 1'b0);
    build_exp(4'b1101, 12'd1, 1'b1);
    for (int i = 0; i < 24; i++) if (i + 96 >= q.size() || q[96+i] !== sig[23-i]) sbad++;
    n_cmp++; if (sbad != 0) begin n_bad++; $display("FAIL r6_signal: %0d SIGNAL bits differ, want 0", sbad); end
    n_cmp++; if (diff() != 0 || q.size() != e.size()) begin n_bad++; $display("FAIL r6_seq: got %0d bits (%0d differ), want %0d", q.size(), diff(), e.size()); end
    n_cmp++; if (q.size() - 150 !== 18) begin n_bad++; $display("FAIL r6_pad: got %0d pad bits, want 18", q.size() - 150); end
    n_cmp++; if (done_cyc - first_v !== 168) begin n_bad++; $display("FAIL r6_done_time: got %0d cycles, want 168", done_cyc - first_v); end
    n_cmp++; if (n_dreq !== 8) begin n_bad++; $display("FAIL r6_datareq: got %0d, want 8", n_dreq); end
    n_cmp++; if (busy_bad !== 0) begin n_bad++; $display("FAIL r6_busy: %0d valid cycles without busy, want 0", busy_bad); end
`ifdef TX_BITCOUNT_EN
    n_cmp++; if (bus.tx_bit_count !== 16'd168) begin n_bad++; $display("FAIL r6_bitcount: got %0d, want 168", bus.tx_bit_count); end
`endif
    @(posedge clk); #2;
    n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
      n_bad++; $display("FAIL r6_after_done: got done=%b busy=%b valid=%b, want 0 0 0", bus.done, bus.busy, bus.tx_valid); end
`ifdef TX_BITCOUNT_EN
    n_cmp++; if (bus.tx_bit_count !== 16'd168) begin n_bad++; $display("FAIL r6_bitcount_hold: got %0d, want 168", bus.tx_bit_count); end
`endif
  endtask

  task automatic test_rate54_len100;
    run_frame(4'b0011, 12'd100, 1'b0, 1'b0, 1'b0);
    build_exp(4'b0011, 12'd100, 1'b0);
    n_cmp++; if (q.size() !== 984) begin n_bad++; $display("FAIL r54_total: got %0d, want 984", q.size()); end
    n_cmp++; if (n_dreq !== 800) begin n_bad++; $display("FAIL r54_datareq: got %0d, want 800", n_dreq); end
    n_cmp++; if (q.size() - 942 !== 42) begin n_bad++; $display("FAIL r54_pad: got %0d, want 42", q.size() - 942); end
    n_cmp++; if (n_init !== 1 || init_at !== 120) begin n_bad++; $display("FAIL r54_scrinit: got %0d pulses at bit %0d, want 1 at 120", n_init, init_at); end
    n_cmp++; if (diff() != 0) begin n_bad++; $display("FAIL r54_seq: got %0d bits differ, want 0", diff()); end
  endtask

  task automatic test_throttle;
    run_frame(4'b0101, 12'd10, 1'b0, 1'b1, 1'b0);
    build_exp(4'b0101, 12'd10, 1'b0);
    n_cmp++; if (q.size() !== 264 || diff() != 0) begin n_bad++; $display("FAIL thr_seq: got %0d bits (%0d differ), want 264", q.size(), diff()); end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL thr_stall: got %0d advance/datareq while not ready, want 0", viol); end
    n_cmp++; if (n_dreq !== 80) begin n_bad++; $display("FAIL thr_datareq: got %0d, want 80", n_dreq); end
  endtask

  task automatic test_error;
    logic [3:0]  rs[2] = '{4'b0100, 4'b1101};
    logic [11:0] ls[2] = '{12'd5, 12'd0};
    for (int k = 0; k < 2; k++) begin
      int ne = 0, nv = 0, nb = 0, first_e = -1;
      bus.start = 1'b1; bus.rate = rs[k]; bus.length = ls[k];
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1; bus.start = 1'b0; #1;
        if (bus.error) begin ne++; if (first_e < 0) first_e = c; end
        if (bus.tx_valid) nv++;
        if (bus.busy) nb++;
      end
      n_cmp++; if (ne !== 1 || first_e !== 0) begin n_bad++; $display("FAIL err%0d_pulse: got %0d pulses first at %0d, want 1 at 0", k, ne, first_e); end
      n_cmp++; if (nv !== 0 || nb !== 0) begin n_bad++; $display("FAIL err%0d_idle: got valid %0d busy %0d cycles, want 0 0", k, nv, nb); end
    end
  endtask

  task automatic test_reset_mid;
    int d = 0, nde = 0;
    bus.start = 1'b1; bus.rate = 4'b1101; bus.length = 12'd50; bus.out_ready = 1'b1; bus.data_in = 1'b1;
    for (int c = 0; c < 400 && d < 20; c++) begin
      @(posedge clk); #1; bus.start = 1'b0; #1;
      if (bus.data_req) d++;
    end
    n_cmp++; if (d !== 20) begin n_bad++; $display("FAIL rstmid_reach: got %0d data bits, want 20", d); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if ({bus.tx_valid, bus.tx_bit, bus.data_req, bus.scr_init, bus.scr_advance, bus.scr_select, bus.busy, bus.done, bus.error} !== 9'h0) begin
      n_bad++; $display("FAIL rstmid_outputs: got valid=%b bit=%b req=%b busy=%b, want all 0", bus.tx_valid, bus.tx_bit, bus.data_req, bus.busy); end
    @(posedge clk); #1; rst = 1'b0; #1;
    if (bus.done || bus.error) nde++;
    @(posedge clk); #2;
    if (bus.done || bus.error || bus.busy) nde++;
    n_cmp++; if (nde !== 0) begin n_bad++; $display("FAIL rstmid_quiet: got %0d cycles with done/error/busy, want 0", nde); end
    run_frame(4'b1101, 12'd50, 1'b0, 1'b0, 1'b0);
    build_exp(4'b1101, 12'd50, 1'b0);
    n_cmp++; if (q.size() !== 552 || diff() != 0) begin n_bad++; $display("FAIL rstmid_frame: got %0d bits (%0d differ), want 552", q.size(), diff()); end
  endtask

  task automatic test_restart;
    run_frame(4'b1101, 12'd1, 1'b1, 1'b0, 1'b1);
    build_exp(4'b1101, 12'd1, 1'b1);
    n_cmp++; if (q.size() !== 168 || diff() != 0 || done_cyc - first_v !== 168) begin
      n_bad++; $display("FAIL restart: got %0d bits (%0d differ) done after %0d, want 168 0 168", q.size(), diff(), done_cyc - first_v); end
  endtask

  task automatic test_back_to_back;
    run_frame(4'b0101, 12'd10, 1'b0, 1'b0, 1'b0);
    build_exp(4'b0101, 12'd10, 1'b0);
    n_cmp++; if (q.size() !== 264 || diff() != 0) begin n_bad++; $display("FAIL b2b_first: got %0d bits (%0d differ), want 264", q.size(), diff()); end
    run_frame(4'b1101, 12'd2, 1'b0, 1'b0, 1'b0);
    build_exp(4'b1101, 12'd2, 1'b0);
    n_cmp++; if (first_v !== 0) begin n_bad++; $display("FAIL b2b_accept: first valid at %0d, want 0", first_v); end
    n_cmp++; if (q.size() !== 168 || diff() != 0) begin n_bad++; $display("FAIL b2b_second: got %0d bits (%0d differ), want 168", q.size(), diff()); end
  endtask

  initial begin
    test_reset();
    test_rate6_len1();
    test_rate54_len100();
    test_throttle();
    test_error();
    test_reset_mid();
    test_restart();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
